// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multi-cycle control sequencer for the RV32I core.
// Owns PC, IR and instret; steps FETCH/DECODE/EXECUTE/MEM/WRITEBACK, traps on faults.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req/addr/ack/rdata      instruction fetch handshake
//   ir_o, opcode_i               IR to decoder, decoded opcode back
//   branch_taken_i, target_i     branch result and jump/branch target (EXECUTE)
//   dmem_req/we/ack              data access handshake
//   rf_we, wb_sel                register-file write strobe and source select
//   pc_o, state_o, instret_o     architectural/debug state
//   trap_o, trap_cause_o         halted flag and cause (01 ill, 10 timeout, 11 misalign)
module riscv_mc_control #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir_o,
   input  logic [6:0]  opcode_i,
   input  logic        branch_taken_i,
   input  logic [31:0] target_i,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic [31:0] pc_o,
   output logic [2:0]  state_o,
   output logic [31:0] instret_o,
   output logic        trap_o,
   output logic [1:0]  trap_cause_o
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd5
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [7:0] WLIM = 8'(MEM_TIMEOUT - 1);

   state_t      state;
   logic [31:0] pc;
   logic [31:0] ir;
   logic [31:0] instret;
   logic [31:0] tgt;
   logic [6:0]  op;
   logic [7:0]  wcnt;
   logic [1:0]  cause;

   logic [31:0] pc4;
   logic        legal;
   logic        is_jump;

   assign pc4     = pc + 32'd4;
   assign is_jump = (op == OP_JAL) || (op == OP_JALR);

   always_comb begin
      legal = 1'b0;
      unique case (1'b1)
         opcode_i == OP_LUI,
         opcode_i == OP_AUIPC,
         opcode_i == OP_JAL,
         opcode_i == OP_JALR,
         opcode_i == OP_BRANCH,
         opcode_i == OP_LOAD,
         opcode_i == OP_STORE,
         opcode_i == OP_IMM,
         opcode_i == OP_OP: legal = 1'b1;
         default:           legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_FETCH;
         pc      <= RESET_PC;
         ir      <= 32'd0;
         instret <= 32'd0;
         tgt     <= 32'd0;
         op      <= 7'd0;
         wcnt    <= 8'd0;
         cause   <= 2'b00;
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_ack) begin
                  ir    <= imem_rdata;
                  wcnt  <= 8'd0;
                  state <= S_DECODE;
               end else if (wcnt == WLIM) begin
                  wcnt  <= 8'd0;
                  cause <= 2'b10;
                  state <= S_TRAP;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            S_DECODE: begin
               // Latch the class so later states do not depend on the decoder.
               op <= opcode_i;
               if (legal) begin
                  state <= S_EXECUTE;
               end else begin
                  cause <= 2'b01;
                  state <= S_TRAP;
               end
            end
            S_EXECUTE: begin
               tgt <= target_i;
               if (op == OP_LOAD || op == OP_STORE) begin
                  state <= S_MEM;
               end else if (op == OP_BRANCH && !branch_taken_i) begin
                  pc      <= pc4;
                  instret <= instret + 32'd1;
                  state   <= S_FETCH;
               end else if (op == OP_BRANCH || is_jump) begin
                  if (target_i[1:0] != 2'b00) begin
                     cause <= 2'b11;
                     state <= S_TRAP;
                  end else if (op == OP_BRANCH) begin
                     pc      <= target_i;
                     instret <= instret + 32'd1;
                     state   <= S_FETCH;
                  end else begin
                     state <= S_WB;
                  end
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_ack) begin
                  wcnt <= 8'd0;
                  if (op == OP_STORE) begin
                     pc      <= pc4;
                     instret <= instret + 32'd1;
                     state   <= S_FETCH;
                  end else begin
                     state <= S_WB;
                  end
               end else if (wcnt == WLIM) begin
                  wcnt  <= 8'd0;
                  cause <= 2'b10;
                  state <= S_TRAP;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            S_WB: begin
               pc      <= is_jump ? tgt : pc4;
               instret <= instret + 32'd1;
               state   <= S_FETCH;
            end
            S_TRAP: begin
               state <= S_TRAP;
            end
            default: begin
               cause <= 2'b01;
               state <= S_TRAP;
            end
         endcase
      end
   end

   // Strobes decode directly from the registered state; rst masks them so
   // both memories see requests drop in the reset cycle itself.
   assign imem_req     = !rst && (state == S_FETCH);
   assign dmem_req     = !rst && (state == S_MEM);
   assign dmem_we      = !rst && (state == S_MEM) && (op == OP_STORE);
   assign rf_we        = !rst && (state == S_WB);
   assign wb_sel       = (rst || state != S_WB) ? 2'b00 :
                         (op == OP_LOAD)        ? 2'b01 :
                         is_jump                ? 2'b10 : 2'b00;
   assign imem_addr    = pc;
   assign pc_o         = pc;
   assign ir_o         = ir;
   assign instret_o    = instret;
   assign state_o      = state;
   assign trap_o       = (state == S_TRAP);
   assign trap_cause_o = cause;

endmodule

// File: tb/tb_riscv_mc_control.sv
// tb_riscv_mc_control: directed stimulus with a queue-based scoreboard.
// Monitor pops expected writeback/retire/trap events as the DUT shows them.
module tb_riscv_mc_control;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ir_o;
   logic [6:0]  opcode_i;
   logic        branch_taken_i;
   logic [31:0] target_i;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic [31:0] pc_o;
   logic [2:0]  state_o;
   logic [31:0] instret_o;
   logic        trap_o;
   logic [1:0]  trap_cause_o;

   // second instance: wrap-around reset PC and minimum timeout
   logic        rst2;
   logic        imem_req2;
   logic [31:0] imem_addr2;
   logic        imem_ack2;
   logic [31:0] imem_rdata2;
   logic [31:0] ir2;
   logic [6:0]  opcode2;
   logic        dmem_req2;
   logic        dmem_we2;
   logic        rf_we2;
   logic [1:0]  wb_sel2;
   logic [31:0] pc2;
   logic [2:0]  state2;
   logic [31:0] instret2;
   logic        trap2;
   logic [1:0]  cause2;

   riscv_mc_control dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir_o(ir_o), .opcode_i(opcode_i),
      .branch_taken_i(branch_taken_i), .target_i(target_i),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .wb_sel(wb_sel), .pc_o(pc_o),
      .state_o(state_o), .instret_o(instret_o),
      .trap_o(trap_o), .trap_cause_o(trap_cause_o)
   );

   riscv_mc_control #(.RESET_PC(32'hFFFF_FFFC), .MEM_TIMEOUT(2)) dut2 (
      .clk(clk), .rst(rst2),
      .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
      .ir_o(ir2), .opcode_i(opcode2),
      .branch_taken_i(1'b0), .target_i(32'd0),
      .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_ack(1'b0),
      .rf_we(rf_we2), .wb_sel(wb_sel2), .pc_o(pc2),
      .state_o(state2), .instret_o(instret2),
      .trap_o(trap2), .trap_cause_o(cause2)
   );

   // decoder stand-in
   assign opcode_i = ir_o[6:0];
   assign opcode2  = ir2[6:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          kind;   // 0 writeback, 1 retire, 2 trap
      logic [31:0] a;      // wb_sel / pc / cause
      logic [31:0] b;      // pc / instret / pc
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input int k, input logic [31:0] a,
                       input logic [31:0] b);
      exp_t e;
      e.kind = k;
      e.a    = a;
      e.b    = b;
      q.push_back(e);
   endtask

   task automatic pop(input int k, input logic [31:0] a,
                      input logic [31:0] b);
      exp_t e;
      if (q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d a=%h b=%h expected none",
                  k, a, b);
      end else begin
         e = q.pop_front();
         chk("event_kind", 32'(k), 32'(e.kind));
         chk(k == 0 ? "wb_sel" : k == 1 ? "retire_pc" : "trap_cause", a, e.a);
         chk(k == 0 ? "wb_pc" : k == 1 ? "instret" : "trap_pc", b, e.b);
      end
   endtask

   // monitor
   logic [31:0] prev_instret = 32'd0;
   logic        prev_trap    = 1'b0;
   logic        prev_rst     = 1'b1;

   always @(negedge clk) begin
      if (!rst && !prev_rst) begin
         if (rf_we)
            pop(0, {30'd0, wb_sel}, pc_o);
         if (instret_o != prev_instret)
            pop(1, pc_o, instret_o);
         if (trap_o && !prev_trap)
            pop(2, {30'd0, trap_cause_o}, pc_o);
      end
      prev_instret = instret_o;
      prev_trap    = trap_o;
      prev_rst     = rst;
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] word, input int dly);
      int n = 0;
      while (!imem_req && n < 50) begin
         cyc();
         n++;
      end
      if (!imem_req) begin
         n_chk++;
         n_fail++;
         $display("FAIL fetch_wait: got imem_req 0 expected 1 within 50 cycles");
      end
      repeat (dly) cyc();
      imem_ack   = 1'b1;
      imem_rdata = word;
      cyc();
      imem_ack   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      rst2 = 1'b1;
      imem_ack = 1'b0;
      imem_rdata = 32'd0;
      branch_taken_i = 1'b0;
      target_i = 32'd0;
      dmem_ack = 1'b0;
      imem_ack2 = 1'b0;
      imem_rdata2 = 32'd0;
      cyc();
      cyc();
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_ir", ir_o, 32'd0);
      chk("rst_instret", instret_o, 32'd0);
      chk("rst_trap", {30'd0, trap_cause_o} | 32'(trap_o), 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      rst = 1'b0;

      // addi x1,x0,5: 0,1,2,4,0
      push(0, 32'd0, 32'h0);
      push(1, 32'h4, 32'd1);
      chk("alu_s0", 32'(state_o), 32'd0);
      fetch(32'h0050_0093, 0);
      chk("alu_s1", 32'(state_o), 32'd1);
      cyc();
      chk("alu_s2", 32'(state_o), 32'd2);
      cyc();
      chk("alu_s4", 32'(state_o), 32'd4);
      chk("alu_rf_we", 32'(rf_we), 32'd1);
      cyc();
      chk("alu_s0_end", 32'(state_o), 32'd0);
      chk("imem_addr", imem_addr, 32'h4);

      // sw x1,0(x0) with 3-cycle dmem delay
      push(1, 32'h8, 32'd2);
      fetch(32'h0010_2023, 0);
      cyc();
      cyc();
      for (int i = 0; i < 4; i++) begin
         chk("st_req", 32'(dmem_req), 32'd1);
         chk("st_we", 32'(dmem_we), 32'd1);
         if (i == 3) dmem_ack = 1'b1;
         cyc();
      end
      dmem_ack = 1'b0;
      chk("st_done_state", 32'(state_o), 32'd0);
      chk("st_done_req", 32'(dmem_req), 32'd0);

      // beq taken, aligned target pc+8
      push(1, 32'h10, 32'd3);
      fetch(32'h0000_0463, 0);
      branch_taken_i = 1'b1;
      target_i = 32'h10;
      cyc();
      cyc();
      branch_taken_i = 1'b0;
      chk("br_state", 32'(state_o), 32'd0);

      // jal at 0x10 -> 0x20; target changes in WB to catch no-latch
      push(0, 32'd2, 32'h10);
      push(1, 32'h20, 32'd4);
      fetch(32'h0100_00EF, 0);
      target_i = 32'h20;
      cyc();
      cyc();
      target_i = 32'h44;
      chk("jal_wb_state", 32'(state_o), 32'd4);
      cyc();

      // lw at 0x20, zero-wait dmem
      push(0, 32'd1, 32'h20);
      push(1, 32'h24, 32'd5);
      fetch(32'h0000_2083, 0);
      cyc();
      cyc();
      chk("ld_we", 32'(dmem_we), 32'd0);
      chk("ld_req", 32'(dmem_req), 32'd1);
      dmem_ack = 1'b1;
      cyc();
      dmem_ack = 1'b0;
      chk("ld_wb_state", 32'(state_o), 32'd4);
      cyc();

      // beq not taken, misaligned target ignored
      push(1, 32'h28, 32'd6);
      fetch(32'h0000_0463, 0);
      target_i = 32'h99;
      cyc();
      cyc();

      // beq taken to pc+6 -> misaligned trap
      push(2, 32'd3, 32'h28);
      fetch(32'h0000_0463, 0);
      branch_taken_i = 1'b1;
      target_i = 32'h2E;
      cyc();
      cyc();
      branch_taken_i = 1'b0;
      chk("mis_state", 32'(state_o), 32'd5);
      chk("mis_trap", 32'(trap_o), 32'd1);
      imem_ack = 1'b1;
      imem_rdata = 32'h0050_0093;
      cyc();
      cyc();
      imem_ack = 1'b0;
      chk("trap_hold_pc", pc_o, 32'h28);
      chk("trap_hold_ir", ir_o, 32'h0000_0463);
      chk("trap_hold_instret", instret_o, 32'd6);
      chk("trap_no_req", 32'(imem_req), 32'd0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rerst_pc", pc_o, 32'd0);
      chk("rerst_state", 32'(state_o), 32'd0);
      chk("rerst_trap", 32'(trap_o), 32'd0);
      chk("rerst_instret", instret_o, 32'd0);

      // illegal opcode
      push(2, 32'd1, 32'h0);
      fetch(32'h0000_0000, 0);
      cyc();
      chk("ill_state", 32'(state_o), 32'd5);
      cyc();
      chk("ill_no_req", 32'(imem_req), 32'd0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("ill_rst_trap", 32'(trap_o), 32'd0);

      // fetch timeout at exactly MEM_TIMEOUT cycles
      push(2, 32'd2, 32'h0);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("to_last_fetch", 32'(state_o), 32'd0);
         cyc();
      end
      chk("to_state", 32'(state_o), 32'd5);
      imem_ack = 1'b1;
      imem_rdata = 32'h0050_0093;
      cyc();
      imem_ack = 1'b0;
      chk("to_late_ack_state", 32'(state_o), 32'd5);
      chk("to_late_ack_ir", ir_o, 32'd0);

      // pc wrap with RESET_PC 0xFFFF_FFFC, then MEM_TIMEOUT=2
      rst2 = 1'b0;
      imem_ack2 = 1'b1;
      imem_rdata2 = 32'h0050_0093;
      cyc();
      imem_ack2 = 1'b0;
      chk("w_s1", 32'(state2), 32'd1);
      cyc();
      cyc();
      chk("w_rf_we", 32'(rf_we2), 32'd1);
      cyc();
      chk("w_pc", pc2, 32'd0);
      chk("w_instret", instret2, 32'd1);
      cyc();
      chk("w_to_fetch", 32'(state2), 32'd0);
      cyc();
      chk("w_to_trap", 32'(state2), 32'd5);
      chk("w_to_cause", 32'(cause2), 32'd2);

      cyc();
      cyc();
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_mc_control.md
Name: riscv_mc_control

Overview:
- Multi-cycle control sequencer for the RV32I core. It owns the PC, the instruction register and the retired-instruction counter.
- Fetches each instruction over an imem req/ack handshake and holds it in the IR, which feeds riscv_decode.
- Uses the decoded opcode, the branch result and the jump/branch target to step each instruction through DECODE, EXECUTE, MEM and WRITEBACK.
- Drives register-file, data-memory and writeback-select controls to the datapath. Traps on illegal opcode, bus timeout or misaligned target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 16, maximum wait cycles for an ack before a bus-timeout trap (range 2..255).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request; held high until ack.
- imem_addr  out  32  fetch address, equal to pc_o.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- ir_o  out  32  instruction register; drives riscv_decode instr.
- opcode_i  in  7  decode.opcode returned from riscv_decode.
- branch_taken_i  in  1  branch comparator result, valid in EXECUTE.
- target_i  in  32  branch/JAL/JALR target from datapath, valid in EXECUTE.
- dmem_req  out  1  data access request; held high until ack.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_ack  in  1  data access complete.
- rf_we  out  1  register-file write strobe, one cycle.
- wb_sel  out  2  writeback source: 00 ALU, 01 load data, 10 pc+4.
- pc_o  out  32  current PC.
- state_o  out  3  FSM state, for debug.
- instret_o  out  32  retired-instruction count.
- trap_o  out  1  core halted in TRAP.
- trap_cause_o  out  2  01 illegal opcode, 10 bus timeout, 11 misaligned target.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5.
  - Codes 6 and 7 go to TRAP with cause 01.
- Reset (rst high at clk edge):
  - state=FETCH, pc_o=RESET_PC, ir_o=0, instret_o=0, wait counter=0, trap_o=0, trap_cause_o=0.
  - While rst is high: imem_req, dmem_req, dmem_we, rf_we and wb_sel are forced to 0.
  - Reset mid-operation discards the in-flight instruction. Both memories must drop outstanding requests on rst.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_o<=imem_rdata, wait counter cleared, go to DECODE.
  - Without ack: increment the wait counter. When it reaches MEM_TIMEOUT-1, go to TRAP with cause 10.
  - An ack arriving while req is low is ignored.
- DECODE (one cycle):
  - opcode_i in {LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011} goes to EXECUTE.
  - Any other opcode goes to TRAP with cause 01.
- EXECUTE (one cycle):
  - OP, OP-IMM, LUI, AUIPC: go to WRITEBACK.
  - LOAD, STORE: go to MEM.
  - BRANCH, not taken: pc<=pc+4, instret++, go to FETCH.
  - BRANCH taken, JAL, JALR: check target_i[1:0].
    - If nonzero: TRAP with cause 11; PC unchanged.
    - BRANCH taken, aligned: pc<=target_i, instret++, go to FETCH.
    - JAL/JALR, aligned: go to WRITEBACK.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE, 0 for LOAD.
  - On dmem_ack: a STORE does pc<=pc+4, instret++ and goes to FETCH. A LOAD goes to WRITEBACK.
  - Timeout rule is the same as FETCH, using a shared counter cleared on each state entry.
- WRITEBACK (one cycle):
  - rf_we=1.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - pc<=target_i (latched in EXECUTE) for JAL/JALR, else pc+4.
  - instret++, go to FETCH.
- TRAP:
  - Absorbing: trap_o=1, trap_cause_o held. No requests, no rf_we, no PC or instret change.
  - Exits only on rst.
- Latency with zero-wait memories:
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Arithmetic widths:
  - pc+4 wraps modulo 2^32 (0xFFFF_FFFC becomes 0x0000_0000).
  - instret_o wraps from 0xFFFF_FFFF to 0.
- imem_addr always equals pc_o. The pc+4 value used for wb_sel=10 is pc_o of the current instruction.

Test Plan:
- Reset, imem returns 0x00500093 (addi x1,x0,5) with same-cycle ack -> states 0,1,2,4,0; rf_we pulses in cycle 4 with wb_sel=00; pc_o=0x4; instret_o=1.
- Store 0x00102023 (sw x1,0(x0)), dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=1 held for 4 cycles; no rf_we; pc_o +4; instret_o +1.
- Branch 0x00000463 (beq x0,x0,8) with branch_taken_i=1, target_i=pc+8 -> FETCH after 3 cycles; pc_o=pc+8; target_i=pc+6 instead -> TRAP, trap_cause_o=11.
- JAL 0x010000EF at pc 0x10 with target_i=0x20 -> WRITEBACK rf_we=1, wb_sel=10; next pc_o=0x20.
- Fetch 0x00000000 -> TRAP, trap_cause_o=01, imem_req stays 0; assert rst for one cycle -> pc_o=RESET_PC, state_o=0, trap_o=0.
- imem_ack withheld for MEM_TIMEOUT cycles -> TRAP with cause 10 exactly at cycle MEM_TIMEOUT; an ack arriving afterwards is ignored.
